// File: rtl/fpu_pkg.sv
// Shared constants for the floating-point operand preparation stage:
// field widths, bias, state codes and special-value classification codes.
package fpu_pkg;

    localparam int unsigned EXP_W  = 8;
    localparam int unsigned MANT_W = 24;
    localparam int unsigned FRAC_W = MANT_W - 1;
    localparam int unsigned BIAS   = 127;
    localparam int unsigned XEXP_W = 10;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned MAX_SHIFT = 24;

    localparam logic [EXP_W-1:0] EXP_ALL_ONES = 8'd255;

    localparam logic [1:0] ESP_NORMAL = 2'b00;
    localparam logic [1:0] ESP_ZERO   = 2'b01;
    localparam logic [1:0] ESP_INF    = 2'b10;
    localparam logic [1:0] ESP_NAN    = 2'b11;

    localparam logic [2:0] OCIOSO     = 3'd0;
    localparam logic [2:0] DECODIFICA = 3'd1;
    localparam logic [2:0] COMPARA    = 3'd2;
    localparam logic [2:0] DESLOCA    = 3'd3;
    localparam logic [2:0] ENTREGA    = 3'd4;

endpackage

// File: rtl/desempacota_pf.sv
// Combinational split of one IEEE-754 single into sign, exponent, 24-bit
// mantissa (hidden bit restored, denormals flushed) and class flags.
// Ports: op (operand in); sinal, expo, mant, is_zero, is_inf, is_nan (out).
module desempacota_pf
    import fpu_pkg::*;
(
    input  logic [31:0]       op,
    output logic              sinal,
    output logic [EXP_W-1:0]  expo,
    output logic [MANT_W-1:0] mant,
    output logic              is_zero,
    output logic              is_inf,
    output logic              is_nan
);

    logic [FRAC_W-1:0] frac;

    assign sinal   = op[31];
    assign expo    = op[30:23];
    assign frac    = op[22:0];
    assign is_zero = (expo == '0);
    assign is_inf  = (expo == EXP_ALL_ONES) && (frac == '0);
    assign is_nan  = (expo == EXP_ALL_ONES) && (frac != '0);
    assign mant    = is_zero ? '0 : {1'b1, frac};

endmodule

// File: rtl/alinhador_pf.sv
// Operand preparation for the FPU: unpacks two singles, classifies special
// values, computes provisional exponent/sign and, for addition, aligns the
// smaller mantissa one bit per cycle before pulsing ula_start to the ALU.
// Ports: clk, rst_n, start, multiplica, op_a, op_b (in);
//        ula_a, ula_b, ula_multiplica, ula_start, exp_out, sinal_out,
//        sub_efetiva, sticky, especial, pronto, ocupado (out, all registered).
module alinhador_pf
    import fpu_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                multiplica,
    input  logic [31:0]         op_a,
    input  logic [31:0]         op_b,
    output logic [MANT_W-1:0]   ula_a,
    output logic [MANT_W-1:0]   ula_b,
    output logic                ula_multiplica,
    output logic                ula_start,
    output logic [XEXP_W-1:0]   exp_out,
    output logic                sinal_out,
    output logic                sub_efetiva,
    output logic                sticky,
    output logic [1:0]          especial,
    output logic                pronto,
    output logic                ocupado
);

    logic [2:0]         state, state_n;
    logic [31:0]        op_a_r, op_a_n, op_b_r, op_b_n;
    logic               mult_r, mult_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [MANT_W-1:0]  ula_a_n, ula_b_n;
    logic               ula_mult_n, ula_start_n, sinal_n, sub_n, sticky_n;
    logic               pronto_n, ocupado_n;
    logic [XEXP_W-1:0]  exp_n;
    logic [1:0]         esp_n;

    logic              sa, sb, za, zb, ia, ib, na, nb;
    logic [EXP_W-1:0]  ea, eb, e_big, e_small, e_diff;
    logic [MANT_W-1:0] ma, mb;
    logic              a_maior;

    desempacota_pf u_dec_a (
        .op(op_a_r), .sinal(sa), .expo(ea), .mant(ma),
        .is_zero(za), .is_inf(ia), .is_nan(na)
    );

    desempacota_pf u_dec_b (
        .op(op_b_r), .sinal(sb), .expo(eb), .mant(mb),
        .is_zero(zb), .is_inf(ib), .is_nan(nb)
    );

    // Ordering by {exp, mant}; ties keep op_a as the larger operand.
    assign a_maior = ({ea, ma} >= {eb, mb});
    assign e_big   = a_maior ? ea : eb;
    assign e_small = a_maior ? eb : ea;
    assign e_diff  = e_big - e_small;

    // Next-state and next-output logic.
    always_comb begin
        state_n     = state;
        op_a_n      = op_a_r;
        op_b_n      = op_b_r;
        mult_n      = mult_r;
        cnt_n       = cnt;
        ula_a_n     = ula_a;
        ula_b_n     = ula_b;
        ula_mult_n  = ula_multiplica;
        exp_n       = exp_out;
        sinal_n     = sinal_out;
        sub_n       = sub_efetiva;
        sticky_n    = sticky;
        esp_n       = especial;
        ula_start_n = 1'b0;
        pronto_n    = 1'b0;

        case (state)
            OCIOSO: begin
                if (start) begin
                    op_a_n     = op_a;
                    op_b_n     = op_b;
                    mult_n     = multiplica;
                    ula_mult_n = multiplica;
                    sticky_n   = 1'b0;
                    state_n    = DECODIFICA;
                end
            end

            DECODIFICA: begin
                sub_n   = 1'b0;
                esp_n   = ESP_NORMAL;
                sinal_n = sa ^ sb;
                if (na || nb) begin
                    esp_n = ESP_NAN;
                end else if (mult_r && ((ia && zb) || (za && ib))) begin
                    esp_n = ESP_NAN;
                end else if (!mult_r && ia && ib && (sa != sb)) begin
                    esp_n = ESP_NAN;
                end else if (ia || ib) begin
                    esp_n   = ESP_INF;
                    sinal_n = ia ? sa : sb;
                end else if (mult_r && (za || zb)) begin
                    esp_n = ESP_ZERO;
                end else if (!mult_r && za && zb) begin
                    esp_n   = ESP_ZERO;
                    sinal_n = sa & sb;
                end

                if (esp_n != ESP_NORMAL) begin
                    state_n  = ENTREGA;
                    pronto_n = 1'b1;
                end else begin
                    state_n = COMPARA;
                end
            end

            COMPARA: begin
                if (mult_r) begin
                    exp_n       = XEXP_W'(ea) + XEXP_W'(eb) - XEXP_W'(BIAS);
                    sinal_n     = sa ^ sb;
                    sub_n       = 1'b0;
                    ula_a_n     = ma;
                    ula_b_n     = mb;
                    state_n     = ENTREGA;
                    pronto_n    = 1'b1;
                    ula_start_n = 1'b1;
                end else begin
                    exp_n   = XEXP_W'(e_big);
                    sinal_n = a_maior ? sa : sb;
                    sub_n   = sa ^ sb;
                    ula_a_n = a_maior ? ma : mb;
                    ula_b_n = a_maior ? mb : ma;
                    cnt_n   = (e_diff > EXP_W'(MAX_SHIFT)) ? CNT_W'(MAX_SHIFT)
                                                           : CNT_W'(e_diff);
                    if (e_diff != '0) begin
                        state_n = DESLOCA;
                    end else begin
                        state_n     = ENTREGA;
                        pronto_n    = 1'b1;
                        ula_start_n = 1'b1;
                    end
                end
            end

            DESLOCA: begin
                ula_b_n  = ula_b >> 1;
                sticky_n = sticky | ula_b[0];
                cnt_n    = cnt - CNT_W'(1);
                if (cnt <= CNT_W'(1)) begin
                    state_n     = ENTREGA;
                    pronto_n    = 1'b1;
                    ula_start_n = 1'b1;
                end
            end

            ENTREGA: begin
                state_n = OCIOSO;
            end

            default: begin
                state_n = OCIOSO;
            end
        endcase

        ocupado_n = (state_n != OCIOSO);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= OCIOSO;
            op_a_r         <= '0;
            op_b_r         <= '0;
            mult_r         <= 1'b0;
            cnt            <= '0;
            ula_a          <= '0;
            ula_b          <= '0;
            ula_multiplica <= 1'b0;
            ula_start      <= 1'b0;
            exp_out        <= '0;
            sinal_out      <= 1'b0;
            sub_efetiva    <= 1'b0;
            sticky         <= 1'b0;
            especial       <= ESP_NORMAL;
            pronto         <= 1'b0;
            ocupado        <= 1'b0;
        end else begin
            state          <= state_n;
            op_a_r         <= op_a_n;
            op_b_r         <= op_b_n;
            mult_r         <= mult_n;
            cnt            <= cnt_n;
            ula_a          <= ula_a_n;
            ula_b          <= ula_b_n;
            ula_multiplica <= ula_mult_n;
            ula_start      <= ula_start_n;
            exp_out        <= exp_n;
            sinal_out      <= sinal_n;
            sub_efetiva    <= sub_n;
            sticky         <= sticky_n;
            especial       <= esp_n;
            pronto         <= pronto_n;
            ocupado        <= ocupado_n;
        end
    end

endmodule

// File: tb/tb_alinhador_pf.sv
// Scoreboard bench for alinhador_pf: directed cases plus randomized operands,
// expected results from a float-level reference model, checked on pronto.
module tb_alinhador_pf;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        multiplica = 1'b0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic [23:0] ula_a, ula_b;
    logic        ula_multiplica, ula_start;
    logic [9:0]  exp_out;
    logic        sinal_out, sub_efetiva, sticky;
    logic [1:0]  especial;
    logic        pronto, ocupado;

    alinhador_pf dut (
        .clk(clk), .rst_n(rst_n), .start(start), .multiplica(multiplica),
        .op_a(op_a), .op_b(op_b), .ula_a(ula_a), .ula_b(ula_b),
        .ula_multiplica(ula_multiplica), .ula_start(ula_start),
        .exp_out(exp_out), .sinal_out(sinal_out), .sub_efetiva(sub_efetiva),
        .sticky(sticky), .especial(especial), .pronto(pronto), .ocupado(ocupado)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   esp;
        bit   chk_sign;
        bit   sgn;
        int   ua;
        int   ub;
        int   ex;
        bit   sub;
        bit   stk;
        bit   mul;
        int   lat;
        int   issue;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   pronto_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at cycle %0d",
                     name, got, got, want, want, cyc);
        end
    endtask

    // Reference model built from the floating-point rules directly.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic mul);
        exp_t r;
        int ea, eb, ma, mb, fa, fb, d, n, ms;
        bit sa, sb, za, zb, ia, ib, na, nb;
        longint ka, kb;
        ea = int'(a[30:23]); eb = int'(b[30:23]);
        fa = int'(a[22:0]);  fb = int'(b[22:0]);
        sa = a[31]; sb = b[31];
        za = (ea == 0); zb = (eb == 0);
        ia = (ea == 255) && (fa == 0); ib = (eb == 255) && (fb == 0);
        na = (ea == 255) && (fa != 0); nb = (eb == 255) && (fb != 0);
        ma = za ? 0 : (fa + (1 << 23));
        mb = zb ? 0 : (fb + (1 << 23));
        r.esp = 0; r.chk_sign = 0; r.sgn = 0; r.ua = 0; r.ub = 0; r.ex = 0;
        r.sub = 0; r.stk = 0; r.mul = mul; r.lat = 2; r.issue = 0;
        if (na || nb)                                r.esp = 3;
        else if (mul && ((ia && zb) || (za && ib)))  r.esp = 3;
        else if (!mul && ia && ib && (sa != sb))     r.esp = 3;
        else if (ia || ib) begin
            r.esp = 2; r.chk_sign = 1; r.sgn = ia ? sa : sb;
        end else if (mul && (za || zb)) begin
            r.esp = 1; r.chk_sign = 1; r.sgn = sa ^ sb;
        end else if (!mul && za && zb)               r.esp = 1;
        else if (mul) begin
            r.ex = ea + eb - 127; r.sgn = sa ^ sb; r.chk_sign = 1;
            r.ua = ma; r.ub = mb; r.lat = 3;
        end else begin
            ka = longint'(ea) * 16777216 + longint'(ma);
            kb = longint'(eb) * 16777216 + longint'(mb);
            d  = (ea > eb) ? ea - eb : eb - ea;
            n  = (d > 24) ? 24 : d;
            if (ka >= kb) begin
                r.ua = ma; ms = mb; r.ex = ea; r.sgn = sa;
            end else begin
                r.ua = mb; ms = ma; r.ex = eb; r.sgn = sb;
            end
            r.chk_sign = 1;
            r.ub  = ms >> n;
            r.stk = (ms % (1 << n)) != 0;
            r.sub = sa ^ sb;
            r.lat = 3 + n;
        end
        return r;
    endfunction

    // Monitor: compare every presented result against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ula_start && !pronto) check("ula_start_without_pronto", 1, 0);
            if (pronto) begin
                pronto_cnt++;
                if (sb_q.size() == 0) begin
                    check("unexpected_pronto", 1, 0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("latency", cyc - e.issue + 1, e.lat);
                    check("especial", int'(especial), e.esp);
                    check("ula_start", int'(ula_start), (e.esp == 0) ? 1 : 0);
                    if (e.chk_sign) check("sinal_out", int'(sinal_out), int'(e.sgn));
                    if (e.esp == 0) begin
                        check("ula_a", int'(ula_a), e.ua);
                        check("ula_b", int'(ula_b), e.ub);
                        check("exp_out", int'($signed(exp_out)), e.ex);
                        check("sub_efetiva", int'(sub_efetiva), int'(e.sub));
                        check("sticky", int'(sticky), int'(e.stk));
                        check("ula_multiplica", int'(ula_multiplica), int'(e.mul));
                    end
                end
            end
        end
    end

    // Issue one operation (caller sits at a negedge) and wait for its result.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic mul, input int repulse);
        exp_t e;
        int t;
        e = model(a, b, mul);
        op_a = a; op_b = b; multiplica = mul; start = 1'b1;
        @(posedge clk); #1;
        e.issue = cyc;
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        check("ocupado_rise", int'(ocupado), 1);
        t = 0;
        while (!pronto && t < 40) begin
            if (repulse > 0 && t == repulse) begin
                start = 1'b1; op_a = $urandom; op_b = $urandom;
                multiplica = 1'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            t++;
        end
        start = 1'b0;
        if (!pronto) check("timeout_pronto", 0, 1);
        @(negedge clk);
        check("ocupado_fall", int'(ocupado), 0);
    endtask

    function automatic logic [31:0] rnd_op(input int base_e);
        int k, e;
        logic [22:0] f;
        k = int'($urandom_range(0, 11));
        f = 23'($urandom);
        if (k == 0) begin
            e = 255;
            if ($urandom_range(0, 1) == 0) f = '0;
        end else if (k == 1) begin
            e = 0;
        end else begin
            e = base_e + int'($urandom_range(0, 40)) - 20;
            if (e < 1) e = 1;
            if (e > 254) e = 254;
        end
        return {1'($urandom), 8'(e), f};
    endfunction

    logic [63:0] all_outs;
    assign all_outs = {ula_a, ula_b, ula_multiplica, ula_start, exp_out,
                       sinal_out, sub_efetiva, sticky, especial, pronto, ocupado};

    initial begin
        int be;
        int pc;
        repeat (3) @(negedge clk);
        check("reset_outputs", int'(all_outs != 64'd0), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_ocupado", int'(ocupado), 0);

        run_op(32'h3F800000, 32'h3F800000, 1'b0, 0);
        run_op(32'h3F000000, 32'h3F800000, 1'b0, 0);
        run_op(32'h3F800000, 32'hB0800001, 1'b0, 0);
        run_op(32'h40000000, 32'hC0400000, 1'b1, 0);
        run_op(32'h7F800000, 32'h00000000, 1'b1, 0);
        run_op(32'hFF800000, 32'h3F800000, 1'b0, 0);
        run_op(32'h7F800000, 32'hFF800000, 1'b0, 0);
        run_op(32'h80000000, 32'h40400000, 1'b1, 0);
        run_op(32'h00000000, 32'h80000000, 1'b0, 0);
        run_op(32'h00000000, 32'h3FC00000, 1'b0, 0);
        run_op(32'h3F800000, 32'hBF800000, 1'b0, 0);
        run_op(32'h7FC00001, 32'h3F800000, 1'b1, 0);
        run_op(32'h00000000, 32'h00000000, 1'b1, 0);
        run_op(32'h00800000, 32'h00800000, 1'b1, 0);
        run_op(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b1, 0);
        // n = 10 with start re-pulsed during the shift
        run_op(32'h3F800000, 32'h3A9ABCDE, 1'b0, 5);

        for (int i = 0; i < 80; i++) begin
            be = int'($urandom_range(1, 254));
            run_op(rnd_op(be), rnd_op(be), 1'($urandom), 0);
        end

        // Reset during shift cycle 5 of an n = 10 add aborts with no pulses.
        op_a = 32'h3F800000; op_b = 32'h3A9ABCDE; multiplica = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        pc = pronto_cnt;
        rst_n = 1'b0;
        #1;
        check("abort_outputs_zero", int'(all_outs != 64'd0), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("abort_no_pronto", pronto_cnt, pc);
        check("abort_idle", int'(ocupado), 0);

        run_op(32'h3F800000, 32'h40000000, 1'b0, 0);
        check("scoreboard_drained", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
